// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address, open-drain SDA, no clock stretching.
// Optional per-line glitch filter enabled by defining I2C_GLITCH_FILTER_EN (FILTER_LEN consecutive samples).
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_hit,
    output logic       rw_mode,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through every stage.
    logic [1:0] pins;
    logic [1:0] meta_reg;
    logic [1:0] sync_reg;
    logic [1:0] line;
    logic [1:0] line_prev_reg;

    assign pins = {sda, scl};

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg      <= 2'b11;
            sync_reg      <= 2'b11;
            line_prev_reg <= 2'b11;
        end else begin
            meta_reg      <= pins;
            sync_reg      <= meta_reg;
            line_prev_reg <= line;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
`ifdef I2C_GLITCH_FILTER_EN
            localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
            logic [CW-1:0] run_reg;
            logic          filt_reg;

            // Output follows the input only after FILTER_LEN consecutive differing samples.
            always_ff @(posedge clk) begin
                if (rst) begin
                    run_reg  <= '0;
                    filt_reg <= 1'b1;
                end else if (sync_reg[gi] == filt_reg) begin
                    run_reg <= '0;
                end else if (run_reg == CW'(FILTER_LEN - 1)) begin
                    run_reg  <= '0;
                    filt_reg <= sync_reg[gi];
                end else begin
                    run_reg <= run_reg + CW'(1);
                end
            end
            assign line[gi] = filt_reg;
`else
            assign line[gi] = sync_reg[gi];
`endif
        end
    endgenerate

`ifndef I2C_GLITCH_FILTER_EN
    logic unused_filter_len;
    assign unused_filter_len = (FILTER_LEN != 0);
`endif

    logic scl_rise, scl_fall, start_cond, stop_cond, sda_line;
    assign sda_line   = line[1];
    assign scl_rise   = line[0] & ~line_prev_reg[0];
    assign scl_fall   = ~line[0] & line_prev_reg[0];
    assign start_cond = line[0] & line_prev_reg[0] & line_prev_reg[1] & ~line[1];
    assign stop_cond  = line[0] & line_prev_reg[0] & ~line_prev_reg[1] & line[1];

    state_t     state_reg, state_next;
    logic [7:0] shift_reg, shift_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       phase_reg, phase_next;
    logic       oe_reg, oe_next;
    logic [7:0] rx_data_reg, rx_data_next;
    logic       rw_reg, rw_next;
    logic       hit_reg, hit_next;
    logic       busy_reg, busy_next;
    logic       tx_req_reg, tx_req_next;
    logic       rx_valid_reg, rx_valid_next;
    logic       stop_reg, stop_next;
    logic [7:0] shifted_in;

    assign shifted_in = {shift_reg[6:0], sda_line};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            shift_reg    <= 8'h00;
            cnt_reg      <= 3'd7;
            phase_reg    <= 1'b0;
            oe_reg       <= 1'b0;
            rx_data_reg  <= 8'h00;
            rw_reg       <= 1'b0;
            hit_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            tx_req_reg   <= 1'b0;
            rx_valid_reg <= 1'b0;
            stop_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            cnt_reg      <= cnt_next;
            phase_reg    <= phase_next;
            oe_reg       <= oe_next;
            rx_data_reg  <= rx_data_next;
            rw_reg       <= rw_next;
            hit_reg      <= hit_next;
            busy_reg     <= busy_next;
            tx_req_reg   <= tx_req_next;
            rx_valid_reg <= rx_valid_next;
            stop_reg     <= stop_next;
        end
    end

    // phase_reg: in ACK states, set once the slot's opening fall has passed;
    // in RD_DATA, set once the last bit's rise has passed; in RD_ACK, set on master ACK.
    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        cnt_next      = cnt_reg;
        phase_next    = phase_reg;
        oe_next       = oe_reg;
        rx_data_next  = rx_data_reg;
        rw_next       = rw_reg;
        hit_next      = hit_reg;
        busy_next     = busy_reg;
        tx_req_next   = 1'b0;
        rx_valid_next = 1'b0;
        stop_next     = 1'b0;
        if (start_cond) begin
            state_next = S_ADDR;
            cnt_next   = 3'd7;
            phase_next = 1'b0;
            oe_next    = 1'b0;
            busy_next  = 1'b1;
            hit_next   = 1'b0;
        end else if (stop_cond) begin
            state_next = S_IDLE;
            phase_next = 1'b0;
            oe_next    = 1'b0;
            busy_next  = 1'b0;
            hit_next   = 1'b0;
            stop_next  = 1'b1;
        end else begin
            case (state_reg)
                S_ADDR: if (scl_rise) begin
                    shift_next = shifted_in;
                    cnt_next   = cnt_reg - 3'd1;
                    if (cnt_reg == 3'd0) begin
                        if (shifted_in[7:1] == SLAVE_ADDR) begin
                            state_next  = S_ADDR_ACK;
                            rw_next     = shifted_in[0];
                            hit_next    = 1'b1;
                            tx_req_next = shifted_in[0];
                            phase_next  = 1'b0;
                        end else begin
                            state_next = S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    if (!phase_reg) begin
                        oe_next    = 1'b1;
                        phase_next = 1'b1;
                    end else begin
                        phase_next = 1'b0;
                        cnt_next   = 3'd7;
                        if (rw_reg) begin
                            shift_next = tx_data;
                            oe_next    = ~tx_data[7];
                            state_next = S_RD_DATA;
                        end else begin
                            oe_next    = 1'b0;
                            state_next = S_WR_DATA;
                        end
                    end
                end
                S_WR_DATA: if (scl_rise) begin
                    shift_next = shifted_in;
                    cnt_next   = cnt_reg - 3'd1;
                    if (cnt_reg == 3'd0) begin
                        rx_data_next  = shifted_in;
                        rx_valid_next = 1'b1;
                        phase_next    = 1'b0;
                        state_next    = S_WR_ACK;
                    end
                end
                S_WR_ACK: if (scl_fall) begin
                    if (!phase_reg) begin
                        oe_next    = 1'b1;
                        phase_next = 1'b1;
                    end else begin
                        oe_next    = 1'b0;
                        phase_next = 1'b0;
                        cnt_next   = 3'd7;
                        state_next = S_WR_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise) begin
                        cnt_next = cnt_reg - 3'd1;
                        if (cnt_reg == 3'd0) begin
                            phase_next = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (phase_reg) begin
                            oe_next    = 1'b0;
                            phase_next = 1'b0;
                            state_next = S_RD_ACK;
                        end else begin
                            shift_next = {shift_reg[6:0], 1'b0};
                            oe_next    = ~shift_reg[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_line) begin
                            tx_req_next = 1'b1;
                            phase_next  = 1'b1;
                        end else begin
                            phase_next = 1'b0;
                            state_next = S_IGNORE;
                        end
                    end else if (scl_fall && phase_reg) begin
                        shift_next = tx_data;
                        oe_next    = ~tx_data[7];
                        cnt_next   = 3'd7;
                        phase_next = 1'b0;
                        state_next = S_RD_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda      = oe_reg ? 1'b0 : 1'bz;
    assign tx_req   = tx_req_reg;
    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign addr_hit = hit_reg;
    assign rw_mode  = rw_reg;
    assign stop_det = stop_reg;
    assign busy     = busy_reg;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bus-level master drives directed and random transfers; expectations come from a transaction model.
`timescale 1ns/1ps
module tb_i2c_slave;
    localparam int         Q    = 6;
    localparam logic [6:0] ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_oe = 1'b0;
    logic [7:0] tx_data = 8'h00;
    wire        sda;
    logic       tx_req, rx_valid, addr_hit, rw_mode, stop_det, busy;
    logic [7:0] rx_data;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int rx_valid_cnt = 0, tx_req_cnt = 0, stop_cnt = 0, slave_low_cnt = 0, hit_cycles = 0;

    logic [7:0] xfer [4];
    logic [7:0] model_rx = 8'h00;

    pullup (sda);
    assign sda = m_oe ? 1'b0 : 1'bz;
    always #5 clk = ~clk;

    i2c_slave #(.SLAVE_ADDR(ADDR), .FILTER_LEN(3)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda),
        .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
        .addr_hit(addr_hit), .rw_mode(rw_mode), .stop_det(stop_det), .busy(busy)
    );

    always @(negedge clk) begin
        if (rx_valid) rx_valid_cnt <= rx_valid_cnt + 1;
        if (tx_req) tx_req_cnt <= tx_req_cnt + 1;
        if (stop_det) stop_cnt <= stop_cnt + 1;
        if (addr_hit) hit_cycles <= hit_cycles + 1;
        if (!m_oe && sda === 1'b0) slave_low_cnt <= slave_low_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic bus_start();
        m_oe = 1'b0; tick(Q);
        scl  = 1'b1; tick(Q);
        m_oe = 1'b1; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; tick(Q);
        scl  = 1'b1; tick(Q);
        m_oe = 1'b0; tick(Q);
    endtask

    // One SCL period starting and ending with SCL low; returns the bus level seen mid-high.
    task automatic bus_bit(input logic b, output logic s);
        m_oe = !b; tick(Q);
        scl  = 1'b1; tick(Q);
        s    = sda; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic bus_bit_glitch(input logic b, output logic s);
        m_oe = !b; tick(Q);
        scl  = 1'b1; tick(3);
        scl  = 1'b0; tick(2);
        scl  = 1'b1; tick(Q);
        s    = sda; tick(Q);
        scl  = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 0; i < 8; i++) bus_bit(b[7-i], d);
        bus_bit(1'b1, ack);
    endtask

    task automatic do_write(input logic [6:0] a, input int n);
        logic ack, hit;
        int   rxv0, stop0, low0, hc0;
        hit   = (a == ADDR);
        rxv0  = rx_valid_cnt; stop0 = stop_cnt; low0 = slave_low_cnt; hc0 = hit_cycles;
        bus_start();
        check_eq("busy_after_start", busy, 1'b1);
        write_byte({a, 1'b0}, ack);
        check_eq("wr_addr_ack", ack, !hit);
        check_eq("wr_addr_hit", addr_hit, hit);
        for (int i = 0; i < n; i++) begin
            write_byte(xfer[i], ack);
            check_eq("wr_data_ack", ack, !hit);
            if (hit) model_rx = xfer[i];
        end
        bus_stop();
        tick(4);
        check_eq("wr_rx_data", rx_data, model_rx);
        check_eq("wr_rx_valid_pulses", rx_valid_cnt - rxv0, hit ? n : 0);
        check_eq("wr_stop_pulses", stop_cnt - stop0, 1);
        check_eq("wr_busy_after_stop", busy, 1'b0);
        check_eq("wr_addr_hit_after_stop", addr_hit, 1'b0);
        if (!hit) begin
            check_eq("miss_sda_never_low", slave_low_cnt - low0, 0);
            check_eq("miss_addr_hit_cycles", hit_cycles - hc0, 0);
        end
        $display("write addr=%02h len=%0d hit=%0b rx_data=%02h", a, n, hit, rx_data);
    endtask

    task automatic do_read(input logic [6:0] a, input int n);
        logic       ack, hit, d;
        logic [7:0] got;
        int         txr0, stop0, low0;
        hit  = (a == ADDR);
        txr0 = tx_req_cnt; stop0 = stop_cnt;
        tx_data = xfer[0];
        bus_start();
        write_byte({a, 1'b1}, ack);
        check_eq("rd_addr_ack", ack, !hit);
        check_eq("rd_addr_hit", addr_hit, hit);
        if (hit) check_eq("rd_rw_mode", rw_mode, 1'b1);
        for (int i = 0; i < n; i++) begin
            got = 8'h00;
            for (int b = 0; b < 8; b++) begin
                bus_bit(1'b1, d);
                got[7-b] = d;
                if (b == 0) tx_data = 8'($urandom);
            end
            tx_data = (i + 1 < n) ? xfer[i+1] : 8'($urandom);
            bus_bit((i + 1 < n) ? 1'b0 : 1'b1, d);
            check_eq("rd_byte", got, hit ? xfer[i] : 8'hFF);
        end
        low0 = slave_low_cnt;
        m_oe = 1'b0;
        tick(4 * Q);
        check_eq("rd_released_after_nack", slave_low_cnt - low0, 0);
        bus_stop();
        tick(4);
        check_eq("rd_tx_req_pulses", tx_req_cnt - txr0, hit ? n : 0);
        check_eq("rd_stop_pulses", stop_cnt - stop0, 1);
        check_eq("rd_busy_after_stop", busy, 1'b0);
        $display("read  addr=%02h len=%0d hit=%0b", a, n, hit);
    endtask

    initial begin
        logic       ack, d, rd;
        logic [7:0] pat, got;
        logic [6:0] a;
        int         n, rxv0;

        rst = 1'b1; tick(4);
        rst = 1'b0; tick(2);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_addr_hit", addr_hit, 1'b0);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_rx_valid", rx_valid, 1'b0);
        check_eq("rst_tx_req", tx_req, 1'b0);
        check_eq("rst_stop_det", stop_det, 1'b0);
        check_eq("rst_rw_mode", rw_mode, 1'b0);
        check_eq("rst_sda_released", sda, 1'b1);

        xfer[0] = 8'hA5; do_write(7'h50, 1);
        xfer[0] = 8'hFF; do_write(7'h51, 1);
        xfer[0] = 8'h3C; xfer[1] = 8'hC3; do_read(7'h50, 2);

        // Repeated START after a partial data byte.
        rxv0 = rx_valid_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("rs_first_addr_ack", ack, 1'b0);
        pat = 8'hB0;
        for (int b = 0; b < 4; b++) bus_bit(pat[7-b], d);
        tx_data = 8'h7E;
        bus_start();
        write_byte(8'hA1, ack);
        check_eq("rs_second_addr_ack", ack, 1'b0);
        check_eq("rs_rw_mode", rw_mode, 1'b1);
        got = 8'h00;
        for (int b = 0; b < 8; b++) begin
            bus_bit(1'b1, d);
            got[7-b] = d;
        end
        bus_bit(1'b1, d);
        check_eq("rs_read_byte", got, 8'h7E);
        bus_stop(); tick(4);
        check_eq("rs_no_rx_valid", rx_valid_cnt - rxv0, 0);
        $display("rep-start addr=50 then read byte=%02h", got);

        // Reset while the slave holds the write ACK low.
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("rm_addr_ack", ack, 1'b0);
        pat = 8'h33;
        for (int b = 0; b < 8; b++) bus_bit(pat[7-b], d);
        m_oe = 1'b0; tick(Q);
        check_eq("rm_ack_driven", sda, 1'b0);
        check_eq("rm_rx_before_rst", rx_data, 8'h33);
        rst = 1'b1; tick(1);
        check_eq("rm_sda_released", sda, 1'b1);
        check_eq("rm_busy", busy, 1'b0);
        check_eq("rm_rx_data", rx_data, 8'h00);
        check_eq("rm_addr_hit", addr_hit, 1'b0);
        rst = 1'b0; scl = 1'b1; model_rx = 8'h00;
        tick(2 * Q);
        $display("reset mid-ack released sda=%0b", sda);
        xfer[0] = 8'h5A; do_write(7'h50, 1);

`ifdef I2C_GLITCH_FILTER_EN
        // Short SCL low pulse inside a data bit must not add a bit.
        rxv0 = rx_valid_cnt;
        bus_start();
        write_byte(8'hA0, ack);
        check_eq("gf_addr_ack", ack, 1'b0);
        pat = 8'h96;
        for (int b = 0; b < 8; b++) begin
            if (b == 3) bus_bit_glitch(pat[7-b], d);
            else bus_bit(pat[7-b], d);
        end
        bus_bit(1'b1, ack);
        check_eq("gf_data_ack", ack, 1'b0);
        bus_stop(); tick(4);
        model_rx = 8'h96;
        check_eq("gf_rx_data", rx_data, model_rx);
        check_eq("gf_rx_valid_pulses", rx_valid_cnt - rxv0, 1);
        $display("glitch write rx_data=%02h", rx_data);
`endif

        for (int t = 0; t < 16; t++) begin
            a  = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom_range(0, 127));
            n  = $urandom_range(1, 3);
            rd = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) xfer[i] = 8'($urandom);
            if (rd) do_read(a, n);
            else do_write(a, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
